// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a bidirectional shift register (d_in/shift_en/dir).
// Define PISO_PARITY_EN to append an even-parity bit (par_valid) after each frame.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             dir_in,
    input  logic             hold,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_dir,
    output logic             busy,
    output logic             frame_done,
    output logic             par_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] data_q;
    logic             accept;
    logic             step;
    logic             last_bit;
    logic             frame_end;
    logic             done_pend;
    logic             s_out_d;

    // Handshake: a word transfers on a rising edge where din_valid && din_ready;
    // din_ready is high only in IDLE, so din_valid is ignored for the rest of the frame.
    assign accept = din_valid && din_ready;

`ifdef PISO_PARITY_EN
    logic par_step;
    assign par_step = (state_q == PAR) && !hold;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
`ifdef PISO_PARITY_EN
                if (last_bit) state_d = PAR;
`else
                if (last_bit) state_d = IDLE;
`endif
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                if (par_step) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output decode: din_ready is combinational, everything else feeds registers.
    always_comb begin
        din_ready = (state_q == IDLE);
        step      = (state_q == SHIFT) && !hold;
        last_bit  = step && (cnt_q == CW'(WIDTH - 1));
        bit_idx   = s_dir ? cnt_q : (CW'(WIDTH - 1) - cnt_q);
        s_out_d   = s_out;
        if (step) s_out_d = data_q[bit_idx];
`ifdef PISO_PARITY_EN
        if (par_step) s_out_d = ^data_q;
        frame_end = par_step;
`else
        frame_end = last_bit;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            data_q     <= '0;
            s_dir      <= 1'b0;
            s_out      <= 1'b0;
            s_valid    <= 1'b0;
            busy       <= 1'b0;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= din;
                s_dir  <= dir_in;
                cnt_q  <= '0;
            end else if (last_bit) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q <= cnt_q + 1'b1;
            end
            s_out      <= s_out_d;
            s_valid    <= step;
            done_pend  <= frame_end;
            frame_done <= done_pend;
            // A word accepted on the frame_done edge keeps busy high (back-to-back).
            if (accept) busy <= 1'b1;
            else if (done_pend) busy <= 1'b0;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_valid <= 1'b0;
        else        par_valid <= par_step;
    end
`else
    assign par_valid = 1'b0;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer with a downstream shift-register model.
// Honours PISO_PARITY_EN so the same bench covers both builds.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         dir_in = 1'b0;
    logic         hold = 1'b0;
    logic         din_ready, s_out, s_valid, s_dir, busy, frame_done, par_valid;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
        .din(din), .dir_in(dir_in), .hold(hold), .s_out(s_out), .s_valid(s_valid),
        .s_dir(s_dir), .busy(busy), .frame_done(frame_done), .par_valid(par_valid)
    );

    always #5 clk = ~clk;

    // Downstream bidirectional shift register: dir 0 shifts left, dir 1 shifts right.
    logic [W-1:0] sr = '0;
    always @(posedge clk) begin
        if (s_valid) sr <= s_dir ? {s_out, sr[W-1:1]} : {sr[W-2:0], s_out};
    end

    logic        obs_q[$];
    logic [63:0] obs_vmask;
    int          obs_done, obs_par_c, obs_dir_bad, obs_overlap, obs_ready_mid;
    logic        obs_par_bit, obs_busy_done, obs_ready_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake at edge k, then walk cycles k+1.. recording what the DUT presents.
    task automatic run_frame(input logic [W-1:0] word, input logic dir,
                             input logic [63:0] hmask, input int vcyc);
        obs_q.delete();
        obs_vmask = '0;
        obs_done = -1; obs_par_c = -1; obs_par_bit = 1'b0;
        obs_dir_bad = 0; obs_overlap = 0; obs_ready_mid = 0;
        obs_busy_done = 1'b0; obs_ready_done = 1'b0;
        din = word; dir_in = dir; din_valid = 1'b1;
        tick();
        din = ~word; dir_in = ~dir;
        for (int c = 1; c <= 60; c++) begin
            hold = hmask[c];
            din_valid = (c < vcyc);
            tick();
            if (s_valid) begin
                obs_q.push_back(s_out);
                obs_vmask[c] = 1'b1;
            end
            if (par_valid) begin
                obs_par_c = c;
                obs_par_bit = s_out;
            end
            if (s_valid && par_valid) obs_overlap++;
            if (s_dir !== dir) obs_dir_bad++;
            if (din_ready && obs_q.size() < W) obs_ready_mid++;
            if (frame_done) begin
                obs_done = c;
                obs_busy_done = busy;
                obs_ready_done = din_ready;
                break;
            end
        end
        hold = 1'b0;
        din_valid = 1'b0;
    endtask

    // Reference timing: every non-held edge advances one step (W data steps, then parity).
    function automatic logic [63:0] model_vmask(input logic [63:0] hmask);
        logic [63:0] m = '0;
        int steps = 0;
        for (int c = 1; c < 64 && steps < W; c++) begin
            if (!hmask[c]) begin
                steps++;
                m[c] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic int model_done(input logic [63:0] hmask);
        int steps = 0;
        for (int c = 1; c < 64; c++) begin
            if (!hmask[c]) begin
                steps++;
                if (steps == W + PAR) return c + 1;
            end
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] pack_obs();
        logic [W-1:0] v = '0;
        foreach (obs_q[i]) v = {v[W-2:0], obs_q[i]};
        return v;
    endfunction

    task automatic test_reset();
        logic [5:0] outs;
        rst_n = 1'b0;
        tick();
        outs = {s_out, s_valid, s_dir, busy, frame_done, par_valid};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs = {s_out, s_valid, s_dir, busy, frame_done, par_valid};
            checks++;
            if (din_ready !== 1'b1 || outs !== 6'b0) begin
                errors++;
                $display("FAIL idle_outputs: got ready=%b outs=%b want ready=1 outs=000000", din_ready, outs);
            end
        end
    endtask

    task automatic test_msb_first();
        run_frame(8'hC1, 1'b0, '0, 0);
        checks++;
        if (obs_q.size() != W || pack_obs() !== 8'b11000001) begin
            errors++;
            $display("FAIL msb_bits: got %0d bits %b want 8 bits 11000001", obs_q.size(), pack_obs());
        end
        checks++;
        if (obs_vmask !== 64'h1FE) begin
            errors++;
            $display("FAIL msb_valid_cycles: got %h want 1fe", obs_vmask);
        end
        checks++;
        if (obs_done != W + 1 + PAR) begin
            errors++;
            $display("FAIL msb_done_cycle: got %0d want %0d", obs_done, W + 1 + PAR);
        end
        checks++;
        if (sr !== 8'hC1) begin
            errors++;
            $display("FAIL msb_reassembled: got %h want c1", sr);
        end
        checks++;
        if (obs_busy_done !== 1'b0 || obs_ready_done !== 1'b1 || obs_ready_mid != 0) begin
            errors++;
            $display("FAIL msb_busy_ready: got busy=%b ready=%b ready_mid=%0d want 0 1 0",
                     obs_busy_done, obs_ready_done, obs_ready_mid);
        end
        checks++;
        if (PAR == 1 ? (obs_par_c != W + 1 || obs_par_bit !== 1'b1) : (obs_par_c != -1)) begin
            errors++;
            $display("FAIL msb_parity: got cycle %0d bit %b want cycle %0d", obs_par_c, obs_par_bit,
                     PAR == 1 ? W + 1 : -1);
        end
    endtask

    task automatic test_lsb_first();
        run_frame(8'hC1, 1'b1, '0, 0);
        checks++;
        if (obs_q.size() != W || pack_obs() !== 8'b10000011) begin
            errors++;
            $display("FAIL lsb_bits: got %0d bits %b want 8 bits 10000011", obs_q.size(), pack_obs());
        end
        checks++;
        if (obs_dir_bad != 0) begin
            errors++;
            $display("FAIL lsb_s_dir: got %0d cycles with s_dir!=1 want 0", obs_dir_bad);
        end
        checks++;
        if (sr !== 8'hC1) begin
            errors++;
            $display("FAIL lsb_reassembled: got %h want c1", sr);
        end
    endtask

    task automatic test_hold();
        logic [63:0] hm;
        int extra;
        hm = 64'h18;
        run_frame(8'h5A, 1'b0, hm, 6);
        checks++;
        if (obs_vmask !== 64'h7E6) begin
            errors++;
            $display("FAIL hold_valid_cycles: got %h want 7e6", obs_vmask);
        end
        checks++;
        if (obs_q.size() != W || pack_obs() !== 8'h5A || sr !== 8'h5A) begin
            errors++;
            $display("FAIL hold_bits: got %0d bits %h sr %h want 8 bits 5a sr 5a", obs_q.size(), pack_obs(), sr);
        end
        checks++;
        if (obs_done != 11 + PAR) begin
            errors++;
            $display("FAIL hold_done_cycle: got %0d want %0d", obs_done, 11 + PAR);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (s_valid || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL hold_no_mid_accept: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int s, last;
        logic ev, eb, ed;
        s = W + PAR + 1;
        last = s + W + PAR + 2;
        din = 8'hFF; dir_in = 1'b0; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 1; c <= last; c++) begin
            din = 8'h00;
            din_valid = (c == s);
            tick();
            ev = (c >= 1 && c <= W) || (c >= s + 1 && c <= s + W);
            eb = (c <= W);
            ed = (c == W + PAR + 1) || (c == s + W + PAR + 1);
            checks++;
            if (s_valid !== ev || (ev && s_out !== eb) || frame_done !== ed) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got valid=%b out=%b done=%b want valid=%b out=%b done=%b",
                         c, s_valid, s_out, frame_done, ev, eb, ed);
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [5:0] outs;
        din = 8'hA5; dir_in = 1'b1; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        #1 rst_n = 1'b0;
        #1;
        outs = {s_out, s_valid, s_dir, busy, frame_done, par_valid};
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b want 000000", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_valid || frame_done || busy || par_valid) seen++;
        end
        checks++;
        if (seen != 0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles ready=%b want 0 and 1", seen, din_ready);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] word;
        logic         dir;
        logic [63:0]  hm;
        logic [W-1:0] exp_v;
        for (int n = 0; n < 10; n++) begin
            word = W'($urandom);
            dir = 1'($urandom_range(0, 1));
            hm = {$urandom, $urandom} & {$urandom, $urandom} & 64'h1F_FFFE;
            exp_v = '0;
            for (int i = 0; i < W; i++) exp_v = {exp_v[W-2:0], dir ? word[i] : word[W-1-i]};
            run_frame(word, dir, hm, $urandom_range(0, 8));
            checks++;
            if (obs_q.size() != W || pack_obs() !== exp_v || sr !== word) begin
                errors++;
                $display("FAIL rand%0d_bits: got %0d bits %h sr %h want %h sr %h", n, obs_q.size(),
                         pack_obs(), sr, exp_v, word);
            end
            checks++;
            if (obs_vmask !== model_vmask(hm) || obs_done != model_done(hm)) begin
                errors++;
                $display("FAIL rand%0d_timing: got mask %h done %0d want mask %h done %0d", n,
                         obs_vmask, obs_done, model_vmask(hm), model_done(hm));
            end
            checks++;
            if (obs_overlap != 0 || obs_dir_bad != 0 ||
                (PAR == 1 && (obs_par_c != obs_done - 1 || obs_par_bit !== ^word))) begin
                errors++;
                $display("FAIL rand%0d_misc: got overlap %0d dir_bad %0d par %0d/%b want 0 0 %0d/%b", n,
                         obs_overlap, obs_dir_bad, obs_par_c, obs_par_bit, obs_done - 1, ^word);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage placed directly upstream of the team's parameterised bidirectional shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per cycle.
- Drives the shift register's serial data input, shift enable and direction inputs, so the shift register reassembles the original word after WIDTH shifts.
- Supports downstream back-pressure and a one-cycle frame-done pulse.

Parameters:
- WIDTH, 8, word length in bits; must be at least 2 and must match the downstream shift register's width.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din_valid  input  1  parallel word offered.
- din_ready  output  1  serializer can accept a word.
- din  input  WIDTH  parallel word.
- dir_in  input  1  direction for this word: 0 = MSB first (left-shifting consumer), 1 = LSB first (right-shifting consumer).
- hold  input  1  downstream stall; freezes shifting.
- s_out  output  1  serial data bit; connects to the shift register's d_in.
- s_valid  output  1  bit valid this cycle; connects to the shift register's shift_en.
- s_dir  output  1  latched direction; connects to the shift register's dir.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last data bit.
- par_valid  output  1  parity bit on s_out (see Optional Feature).

Behaviour:
- The interface is one clock (clk) with an asynchronous, active-low reset (rst_n). Reset takes effect immediately, independent of clk.
- All outputs are registered except din_ready, which is decoded directly from state.
- Reset values:
  - State = IDLE.
  - s_out, s_valid, s_dir, busy, frame_done, par_valid = 0.
  - Bit counter = 0; data register = 0.
  - din_ready = 1 once rst_n is released.
- State machine:
  - IDLE: din_ready = 1. On a clk edge with din_valid && din_ready:
    - latch din and dir_in;
    - clear the counter;
    - go to SHIFT;
    - busy = 1 from the next cycle.
  - SHIFT: din_ready = 0. Each cycle with hold = 0:
    - s_valid = 1;
    - s_out = data[WIDTH-1-cnt] when the latched dir = 0, else data[cnt];
    - cnt increments.
  - SHIFT with hold = 1: s_valid = 0, s_out holds its last value, cnt is frozen.
  - After the bit with cnt == WIDTH-1 has been presented, the next state is IDLE (or PAR, see Optional Feature).
- Latency and frame timing, with the handshake at edge k:
  - data bits are valid in cycles k+1 .. k+WIDTH when there are no stalls;
  - in cycle k+WIDTH+1: frame_done = 1, busy = 0, din_ready = 1.
  - A back-to-back word accepted at that edge starts its bits at k+WIDTH+2, giving exactly one bubble cycle between frames.
- s_dir changes only at handshake acceptance and is stable for the whole frame.
- din_valid is ignored outside IDLE; din and dir_in changing mid-frame have no effect.
- hold in IDLE has no effect. hold asserted on the cycle of the last bit delays that bit; frame_done follows the cycle after the bit is actually presented.
- Asserting rst_n low mid-frame:
  - aborts immediately;
  - all outputs return to reset values;
  - no frame_done pulse is produced.
- Without the Optional Feature, s_valid and par_valid are never 1 in the same cycle (par_valid is tied 0).

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit the FSM enters PAR for one cycle with hold = 0.
  - In PAR: s_out = even parity (XOR of the latched word), par_valid = 1, s_valid = 0, so the shift register does not shift.
  - hold stalls PAR the same way it stalls SHIFT.
  - frame_done follows PAR, so each frame is one cycle longer.
- Undefined: the PAR state is absent, par_valid is tied 0, and timing is exactly as in Behaviour.

Test Plan:
- Reset, then idle for 3 cycles: din_ready = 1, all other outputs 0.
- din = 8'hC1, dir_in = 0, handshake at edge k: s_out = 1,1,0,0,0,0,0,1 with s_valid = 1 in cycles k+1..k+8; frame_done in k+9; downstream shift register q_out = 8'hC1.
- din = 8'hC1, dir_in = 1: s_out = 1,0,0,0,0,0,1,1, s_dir = 1; downstream right-shifting register q_out = 8'hC1.
- 8'h5A with hold = 1 for cycles k+3 and k+4: s_valid = 0 in those cycles, no bit lost, frame_done in k+11; din_valid held high mid-frame is not accepted.
- Two back-to-back words 8'hFF then 8'h00: one bubble cycle between frames; second frame's first bit in k+10.
- Reset pulsed at k+4 mid-frame: outputs cleared at once, no frame_done. With PISO_PARITY_EN defined, 8'hC1 gives par_valid = 1 and s_out = 1 in k+9, with frame_done in k+10.
